// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two WIDTH-bit unsigned operands four bits per clock through one 4-bit
//   ripple-carry slice. The carry between nibbles lives in carry_r, so a full
//   add takes N = WIDTH/4 RUN cycles. Operands arrive on a valid/ready input
//   handshake and the result leaves on a valid/ready output handshake.
//   WIDTH must be a multiple of 4 and at least 4.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a, b, cin are valid
//   in_ready   block can accept operands (state == IDLE)
//   a, b       operands, sampled on accept
//   cin        carry into nibble 0, sampled on accept
//   out_valid  sum/cout hold a finished result (state == DONE)
//   out_ready  sink takes the result
//   sum        registered (a + b + cin) mod 2^WIDTH
//   cout       registered carry out of the top nibble

// 4-bit ripple-carry slice. This is the only adder in the datapath.
module nibble_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  always_comb begin
    logic c;
    // NOTE: combinational logic uses blocking '=' so each bit sees the carry
    // produced by the bit below it in the same evaluation.
    c   = cin;
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r;
  logic             carry_r;
  logic [IDX_W-1:0] idx;

  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] sum_shift;
  logic             accept;
  logic             last_step;

  nibble_slice u_slice (
    .a   (a_sh[3:0]),
    .b   (b_sh[3:0]),
    .cin (carry_r),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  // New nibble enters at the top; after N steps nibble 0 has reached bit 0.
  // Written as shift-and-or so WIDTH=4 needs no special case.
  assign sum_shift = (sum_r >> 4) | (WIDTH'(slice_sum) << (WIDTH - 4));

  assign accept    = (state == IDLE) && in_valid;
  assign last_step = (idx == IDX_W'(N - 1));

  // Handshake outputs are pure state decodes: no path from in_valid/out_ready.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = carry_r;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: next-state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE: if (in_valid)  state_next = RUN;
      RUN:  if (last_step) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, because sum/cout are driven
  // straight from them and must read 0 while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      carry_r <= cin;
      idx     <= '0;
    end else if (state == RUN) begin
      sum_r   <= sum_shift;
      a_sh    <= a_sh >> 4;
      b_sh    <= b_sh >> 4;
      carry_r <= slice_cout;
      idx     <= idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder. Three instances share clk and
// rst_n: index 0 is WIDTH=4, index 1 is WIDTH=16 (main directed tests),
// index 2 is WIDTH=32. Inputs change 1 ns after the rising edge and outputs
// are sampled there too.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        iv[3], orr[3], cin_i[3];
  logic [31:0] a_i[3], b_i[3];
  logic        ir[3], ov[3], co[3];
  logic [31:0] sm[3];
  logic [3:0]  sum4;
  logic [15:0] sum16;
  logic [31:0] sum32;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign sm[0] = {28'd0, sum4};
  assign sm[1] = {16'd0, sum16};
  assign sm[2] = sum32;

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_i[0][3:0]), .b(b_i[0][3:0]), .cin(cin_i[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .sum(sum4), .cout(co[0])
  );

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_i[1][15:0]), .b(b_i[1][15:0]), .cin(cin_i[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .sum(sum16), .cout(co[1])
  );

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_i[2]), .b(b_i[2]), .cin(cin_i[2]),
    .out_valid(ov[2]), .out_ready(orr[2]), .sum(sum32), .cout(co[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation on instance k. Leaves the result in DONE if out_ready is 0,
  // otherwise lets it transfer and checks the return to IDLE.
  task automatic run_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic [31:0] es, input logic ec,
                        input int lat, input string tag);
    int n = 0;
    while (!ir[k] && n < 50) begin step(); n++; end
    check({tag, "_in_ready"}, 64'(ir[k]), 64'd1);
    a_i[k] = av; b_i[k] = bv; cin_i[k] = ci; iv[k] = 1'b1;
    step();
    iv[k] = 1'b0;
    check({tag, "_busy"}, 64'(ir[k]), 64'd0);
    n = 0;
    while (!ov[k] && n < 50) begin step(); n++; end
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_sum"}, 64'(sm[k]), 64'(es));
    check({tag, "_cout"}, 64'(co[k]), 64'(ec));
    if (orr[k]) begin
      step();
      check({tag, "_released"}, {62'd0, ov[k], ir[k]}, 64'b01);
    end
  endtask

  // Back-to-back stream of three ops with in_valid and out_ready held high.
  task automatic b2b(input int k, input int period, input logic [31:0] av[3],
                     input logic [31:0] bv[3], input logic ci[3],
                     input logic [31:0] es[3], input logic ec[3], input string tag);
    int n = 0, got = 0, sent = 0, last_acc = -1;
    logic acc;
    orr[k] = 1'b1;
    a_i[k] = av[0]; b_i[k] = bv[0]; cin_i[k] = ci[0]; iv[k] = 1'b1;
    while (got < 3 && n < 100) begin
      acc = ir[k] && iv[k];
      if (ov[k]) begin
        check($sformatf("%s_sum%0d", tag, got), 64'(sm[k]), 64'(es[got]));
        check($sformatf("%s_cout%0d", tag, got), 64'(co[k]), 64'(ec[got]));
        got++;
      end
      step();
      n++;
      if (acc) begin
        if (last_acc >= 0)
          check($sformatf("%s_period%0d", tag, sent), 64'(n - last_acc), 64'(period));
        last_acc = n;
        sent++;
        if (sent < 3) begin
          a_i[k] = av[sent]; b_i[k] = bv[sent]; cin_i[k] = ci[sent];
        end else begin
          iv[k] = 1'b0;
        end
      end
    end
    check({tag, "_results"}, 64'(got), 64'd3);
  endtask

  initial begin
    logic [31:0] av[3], bv[3], es[3];
    logic        ci[3], ec[3];

    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; orr[k] = 1'b1; cin_i[k] = 1'b0; a_i[k] = '0; b_i[k] = '0;
    end

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset_flags", {62'd0, ir[1], ov[1]}, 64'b10);
    check("reset_sum", 64'(sm[1]), 64'd0);
    check("reset_cout", 64'(co[1]), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step();

    run_op(1, 32'h1234, 32'h4321, 1'b0, 32'h5555, 1'b0, 4, "add_5555");
    run_op(1, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 4, "carry_chain");
    run_op(1, 32'hFFFF, 32'h0000, 1'b1, 32'h0000, 1'b1, 4, "cin_chain");
    run_op(1, 32'h8000, 32'h8000, 1'b0, 32'h0000, 1'b1, 4, "top_carry");

    // Backpressure: result held for 5 cycles while in_valid/a/b wiggle.
    orr[1] = 1'b0;
    run_op(1, 32'h0F0F, 32'h0101, 1'b1, 32'h1011, 1'b0, 4, "bp");
    for (int i = 0; i < 5; i++) begin
      iv[1] = i[0] ? 1'b0 : 1'b1;
      a_i[1] = 32'h1111 * (i + 1);
      b_i[1] = 32'h2222 * (i + 1);
      step();
      check($sformatf("bp_hold_flags%0d", i), {62'd0, ov[1], ir[1]}, 64'b10);
      check($sformatf("bp_hold_sum%0d", i), 64'(sm[1]), 64'h1011);
      check($sformatf("bp_hold_cout%0d", i), 64'(co[1]), 64'd0);
    end
    // in_valid high on the transfer edge: no accept there, IDLE follows.
    a_i[1] = 32'h0002; b_i[1] = 32'h0003; cin_i[1] = 1'b0; iv[1] = 1'b1;
    orr[1] = 1'b1;
    step();
    check("bp_transfer_flags", {62'd0, ov[1], ir[1]}, 64'b01);
    run_op(1, 32'h0002, 32'h0003, 1'b0, 32'h0005, 1'b0, 4, "after_bp");

    // Asynchronous reset in the 2nd RUN cycle.
    a_i[1] = 32'hAAAA; b_i[1] = 32'h5555; cin_i[1] = 1'b0; iv[1] = 1'b1;
    step();
    iv[1] = 1'b0;
    step();
    #3 rst_n = 1'b0;
    #1;
    check("midrun_rst_flags", {62'd0, ir[1], ov[1]}, 64'b10);
    check("midrun_rst_sum", 64'(sm[1]), 64'd0);
    check("midrun_rst_cout", 64'(co[1]), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    run_op(1, 32'h00FF, 32'h0001, 1'b0, 32'h0100, 1'b0, 4, "post_rst");

    // Back-to-back streams.
    av = '{32'hBEEF, 32'hC000, 32'h7FFF};
    bv = '{32'h1234, 32'h4000, 32'h7FFF};
    ci = '{1'b1, 1'b0, 1'b1};
    es = '{32'hD124, 32'h0000, 32'hFFFF};
    ec = '{1'b0, 1'b1, 1'b0};
    b2b(1, 6, av, bv, ci, es, ec, "b2b16");

    av = '{32'h9, 32'h7, 32'h3};
    bv = '{32'h8, 32'h8, 32'h4};
    ci = '{1'b0, 1'b1, 1'b1};
    es = '{32'h1, 32'h0, 32'h8};
    ec = '{1'b1, 1'b1, 1'b0};
    b2b(0, 3, av, bv, ci, es, ec, "b2b4");

    av = '{32'hFFFFFFFF, 32'h12345678, 32'hDEADBEEF};
    bv = '{32'h00000001, 32'h87654321, 32'h21524110};
    ci = '{1'b0, 1'b0, 1'b1};
    es = '{32'h00000000, 32'h99999999, 32'h00000000};
    ec = '{1'b1, 1'b0, 1'b1};
    b2b(2, 10, av, bv, ci, es, ec, "b2b32");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
